// File: rtl/reset_seq_gen_pkg.sv
// Shared types and constants for the multi-channel reset sequencer.
//   rsg_state_e : sequencer FSM states
//   COUNT_W     : width of the cycle counter
package reset_seq_gen_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } rsg_state_e;

    localparam int COUNT_W = 32;

endpackage

// File: rtl/reset_seq_gen.sv
// Multi-channel reset sequencer. Holds all reset outputs asserted through an
// initial delay and a programmable assert time, then releases the channels one
// by one (ch0 first, STAGGER cycles apart) or all together when STAGGER is 0.
// A hold input keeps the channels asserted; a retrigger input restarts the
// assert phase from ASSERT, RELEASE or DONE.
//
// Ports:
//   clock     in   1           rising-edge clock
//   reset_n   in   1           asynchronous active-low block reset
//   retrigger in   1           level, sampled per edge: restart the assert phase
//   hold      in   1           1 = keep all channels asserted in ASSERT
//   rst_o     out  N_CHANNELS  active-high resets, bit i = channel i (registered)
//   rst_n_o   out  N_CHANNELS  active-low copy of rst_o
//   done      out  1           1 = all channels released (registered)
//
// The current FSM state is visible as the internal signal state_q for checkers.
module reset_seq_gen
    import reset_seq_gen_pkg::*;
#(
    parameter int unsigned N_CHANNELS    = 4,
    parameter int unsigned INITIAL_DELAY = 2,
    parameter int unsigned ASSERT_COUNT  = 20,
    parameter int unsigned STAGGER       = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  retrigger,
    input  logic                  hold,
    output logic [N_CHANNELS-1:0] rst_o,
    output logic [N_CHANNELS-1:0] rst_n_o,
    output logic                  done
);

    localparam int CH_W = $clog2(N_CHANNELS + 1);

    localparam logic [COUNT_W-1:0] INIT_CNT   = COUNT_W'(INITIAL_DELAY);
    localparam logic [COUNT_W-1:0] ASSERT_CNT = COUNT_W'(ASSERT_COUNT);
    localparam logic [COUNT_W-1:0] STAGGER_CNT = COUNT_W'(STAGGER);
    localparam logic [CH_W-1:0]    LAST_CH    = CH_W'(N_CHANNELS - 1);

    generate
        if (N_CHANNELS < 1) begin : g_bad_channels
            $error("reset_seq_gen: N_CHANNELS must be at least 1");
        end
    endgenerate

    rsg_state_e            state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [N_CHANNELS-1:0] rst_q, rst_d;
    logic                  done_q, done_d;

    // Exit condition from ASSERT: count has reached its target and nobody holds.
    logic assert_exit;
    assign assert_exit = (count_q == ASSERT_CNT) && !hold;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            count_q <= '0;
            ch_q    <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: begin
                if (count_q == INIT_CNT) state_d = ASSERT;
            end
            ASSERT: begin
                if (!retrigger && assert_exit) begin
                    // With a single channel, releasing ch0 finishes the sequence.
                    if (STAGGER == 0 || N_CHANNELS == 1) state_d = DONE;
                    else                                 state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (retrigger)                                       state_d = ASSERT;
                else if (count_q == STAGGER_CNT && ch_q == LAST_CH)  state_d = DONE;
            end
            DONE: begin
                if (retrigger) state_d = ASSERT;
            end
            default: state_d = INIT;
        endcase
    end

    // Datapath / registered-output next values.
    always_comb begin
        count_d = count_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        done_d  = done_q;
        unique case (state_q)
            INIT: begin
                if (count_q == INIT_CNT) count_d = '0;
                else                     count_d = count_q + 1'b1;
            end
            ASSERT: begin
                rst_d = '1;
                if (retrigger) begin
                    count_d = '0;
                end else if (assert_exit) begin
                    if (STAGGER == 0) begin
                        rst_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        rst_d[0] = 1'b0;
                        ch_d     = CH_W'(1);
                        count_d  = '0;
                        if (N_CHANNELS == 1) done_d = 1'b1;
                    end
                end else if (count_q < ASSERT_CNT) begin
                    // hold leaves count parked at ASSERT_CNT.
                    count_d = count_q + 1'b1;
                end
            end
            RELEASE: begin
                if (retrigger) begin
                    rst_d   = '1;
                    count_d = '0;
                    ch_d    = '0;
                end else if (count_q == STAGGER_CNT) begin
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        if (ch_q == CH_W'(i)) rst_d[i] = 1'b0;
                    end
                    count_d = '0;
                    ch_d    = ch_q + 1'b1;
                    if (ch_q == LAST_CH) done_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                rst_d = '0;
                if (retrigger) begin
                    rst_d   = '1;
                    done_d  = 1'b0;
                    count_d = '0;
                    ch_d    = '0;
                end
            end
            default: begin
                count_d = '0;
                ch_d    = '0;
                rst_d   = '1;
                done_d  = 1'b0;
            end
        endcase
    end

    // Outputs.
    assign rst_o   = rst_q;
    assign rst_n_o = ~rst_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen: a default instance (4 channels, stagger 4)
// and a wide instance (8 channels, stagger 0) share clock and reset_n.
// Expected {done, rst_o, rst_n_o} vectors are queued when a step is driven and
// popped when the outputs are sampled, #1 after each rising edge.
module tb_reset_seq_gen;

    logic       clock;
    logic       reset_n;
    logic       retrigger;
    logic       hold;
    logic [3:0] rst_o;
    logic [3:0] rst_n_o;
    logic       done;

    logic       retrigger8;
    logic       hold8;
    logic [7:0] rst8_o;
    logic [7:0] rst8_n_o;
    logic       done8;

    logic [8:0]  exp_q[$];
    logic [16:0] exp8_q[$];

    int edge_cnt;
    int errors;
    int checks;

    reset_seq_gen dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .retrigger (retrigger),
        .hold      (hold),
        .rst_o     (rst_o),
        .rst_n_o   (rst_n_o),
        .done      (done)
    );

    reset_seq_gen #(
        .N_CHANNELS (8),
        .STAGGER    (0)
    ) dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .retrigger (retrigger8),
        .hold      (hold8),
        .rst_o     (rst8_o),
        .rst_n_o   (rst8_n_o),
        .done      (done8)
    );

    // Clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Queue one expectation per instance: e = {done, rst_o}.
    task automatic push_exp(input logic [4:0] e, input logic [8:0] e8);
        exp_q.push_back({e, ~e[3:0]});
        exp8_q.push_back({e8, ~e8[7:0]});
    endtask

    // Pop both expectations and compare against the sampled outputs.
    task automatic compare(input string tag);
        logic [8:0]  exp;
        logic [16:0] exp8;
        logic [8:0]  obs;
        logic [16:0] obs8;
        exp  = exp_q.pop_front();
        exp8 = exp8_q.pop_front();
        obs  = {done, rst_o, rst_n_o};
        obs8 = {done8, rst8_o, rst8_n_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d {done,rst_o,rst_n_o} got=%h want=%h", tag, edge_cnt, obs, exp);
        end
        checks++;
        assert (obs8 === exp8) else begin
            errors++;
            $error("FAIL %s_w8 edge=%0d {done,rst_o,rst_n_o} got=%h want=%h", tag, edge_cnt, obs8, exp8);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        edge_cnt++;
        #1;
    endtask

    // Advance edge by edge up to last_edge, checking every edge.
    task automatic run_expect(input int last_edge, input logic [4:0] e,
                              input logic [8:0] e8, input string tag);
        while (edge_cnt < last_edge) begin
            push_exp(e, e8);
            tick();
            compare(tag);
        end
    endtask

    // Reset both instances for 5 cycles; edge 1 is the next rising edge.
    task automatic do_reset();
        reset_n    = 1'b0;
        retrigger  = 1'b0;
        hold       = 1'b0;
        retrigger8 = 1'b0;
        hold8      = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        edge_cnt = 0;
        push_exp(5'h0F, 9'h0FF);
        compare("in_reset");
        reset_n = 1'b1;
    endtask

    // Default release timeline up to a given edge.
    task automatic default_seq(input int last_edge, input string tag);
        run_expect((last_edge < 23) ? last_edge : 23, 5'h0F, 9'h0FF, tag);
        if (last_edge >= 24) run_expect((last_edge < 28) ? last_edge : 28, 5'h0E, 9'h100, tag);
        if (last_edge >= 29) run_expect((last_edge < 33) ? last_edge : 33, 5'h0C, 9'h100, tag);
        if (last_edge >= 34) run_expect((last_edge < 38) ? last_edge : 38, 5'h08, 9'h100, tag);
        if (last_edge >= 39) run_expect(last_edge, 5'h10, 9'h100, tag);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        edge_cnt   = 0;
        reset_n    = 1'b0;
        retrigger  = 1'b0;
        hold       = 1'b0;
        retrigger8 = 1'b0;
        hold8      = 1'b0;

        // Defaults timeline; wide instance releases all at edge 24.
        do_reset();
        default_seq(45, "default");

        // hold through edge 40, then staggered release from edge 41.
        do_reset();
        hold = 1'b1;
        run_expect(23, 5'h0F, 9'h0FF, "hold");
        run_expect(40, 5'h0F, 9'h100, "hold");
        hold = 1'b0;
        run_expect(45, 5'h0E, 9'h100, "hold_rel");
        run_expect(50, 5'h0C, 9'h100, "hold_rel");
        run_expect(55, 5'h08, 9'h100, "hold_rel");
        run_expect(58, 5'h10, 9'h100, "hold_rel");

        // retrigger during RELEASE at edge 31.
        do_reset();
        default_seq(30, "retrig_rel_pre");
        retrigger = 1'b1;
        run_expect(31, 5'h0F, 9'h100, "retrig_rel");
        retrigger = 1'b0;
        run_expect(51, 5'h0F, 9'h100, "retrig_rel");
        run_expect(56, 5'h0E, 9'h100, "retrig_rel");
        run_expect(61, 5'h0C, 9'h100, "retrig_rel");
        run_expect(66, 5'h08, 9'h100, "retrig_rel");
        run_expect(70, 5'h10, 9'h100, "retrig_rel");

        // retrigger in DONE at edge 50; wide instance retriggered too.
        do_reset();
        default_seq(49, "retrig_done_pre");
        retrigger  = 1'b1;
        retrigger8 = 1'b1;
        run_expect(50, 5'h0F, 9'h0FF, "retrig_done");
        retrigger  = 1'b0;
        retrigger8 = 1'b0;
        run_expect(70, 5'h0F, 9'h0FF, "retrig_done");
        run_expect(71, 5'h0E, 9'h100, "retrig_done");
        run_expect(73, 5'h0E, 9'h100, "retrig_done");

        // Asynchronous reset mid-RELEASE, then the full sequence again.
        do_reset();
        default_seq(30, "async_pre");
        #2;
        reset_n = 1'b0;
        #1;
        push_exp(5'h0F, 9'h0FF);
        compare("async_rst");
        do_reset();
        default_seq(40, "after_async");

        if (exp_q.size() != 0 || exp8_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_exp got=%0d want=0", exp_q.size() + exp8_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
